// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b type definitions and memory-op helpers.
package lc3b_types;
  typedef enum logic [2:0] {
    MOP_NONE,
    MOP_LDR,
    MOP_STR,
    MOP_LDB,
    MOP_STB,
    MOP_LDI,
    MOP_STI
  } lc3b_memop;
  function automatic logic is_store(input lc3b_memop op);
    return op == MOP_STR || op == MOP_STB || op == MOP_STI;
  endfunction
  function automatic logic is_byte(input lc3b_memop op);
    return op == MOP_LDB || op == MOP_STB;
  endfunction
endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: byte lane select for loads, replicate and enable for stores.
module mem_byte_lane (
  input  logic        i_sel,
  input  logic [15:0] i_rdata,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic [15:0] o_wdata,
  output logic [1:0]  o_wmask
);
  assign o_rdata = {8'h00, i_sel ? i_rdata[15:8] : i_rdata[7:0]};
  assign o_wdata = {i_wdata[7:0], i_wdata[7:0]};
  assign o_wmask = i_sel ? 2'b10 : 2'b01;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data memory sequencer with pipeline stall.
// LC3B_INDIRECT_EN adds the IND pointer-fetch state for LDI/STI.
module mem_access_ctrl
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_address,
  input  logic [15:0] req_wdata,
  output logic [15:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_wmask,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall,
  output logic [15:0] mem_rdata,
  output logic        mem_done
);
  typedef enum logic [1:0] {
    S_IDLE,
`ifdef LC3B_INDIRECT_EN
    S_IND,
`endif
    S_ACC,
    S_DONE
  } mem_state;
  mem_state r_state;
  lc3b_memop r_op;
  logic [15:0] r_addr, r_wdata, r_rdata;
  logic [15:0] w_base, w_eff, w_lane_rdata, w_lane_wdata;
  logic [1:0] w_lane_wmask;
  logic w_store, w_byte, w_acc, w_in_ind;
`ifdef LC3B_INDIRECT_EN
  logic [15:0] r_ptr;
  assign w_base = (r_op == MOP_LDI || r_op == MOP_STI) ? r_ptr : r_addr;
  assign w_in_ind = r_state == S_IND;
`else
  assign w_base = r_addr;
  assign w_in_ind = 1'b0;
`endif
  assign w_store = is_store(r_op);
  assign w_byte = is_byte(r_op);
  assign w_acc = r_state == S_ACC;
  assign w_eff = w_byte ? w_base : {w_base[15:1], 1'b0};
  mem_byte_lane u_lane (
    .i_sel   (w_eff[0]),
    .i_rdata (dmem_rdata),
    .i_wdata (r_wdata),
    .o_rdata (w_lane_rdata),
    .o_wdata (w_lane_wdata),
    .o_wmask (w_lane_wmask)
  );
  // Strobes and bus fields are forced to zero outside the access states
  assign dmem_read = (w_acc && !w_store) || w_in_ind;
  assign dmem_write = w_acc && w_store;
  assign dmem_address = w_in_ind ? {r_addr[15:1], 1'b0} : w_acc ? w_eff : 16'h0000;
  assign dmem_wmask = w_acc ? (w_byte ? w_lane_wmask : 2'b11) : 2'b00;
  assign dmem_wdata = dmem_write ? (w_byte ? w_lane_wdata : r_wdata) : 16'h0000;
  assign mem_stall = req_valid && req_op != MOP_NONE && r_state != S_DONE;
  assign mem_done = r_state == S_DONE;
  assign mem_rdata = r_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op <= MOP_NONE;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef LC3B_INDIRECT_EN
      r_ptr <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (req_valid && req_op != MOP_NONE) begin
          r_op <= lc3b_memop'(req_op);
          r_addr <= req_address;
          r_wdata <= req_wdata;
`ifdef LC3B_INDIRECT_EN
          r_state <= (req_op == MOP_LDI || req_op == MOP_STI) ? S_IND : S_ACC;
`else
          r_state <= S_ACC;
`endif
        end
`ifdef LC3B_INDIRECT_EN
        S_IND: if (dmem_resp) begin
          r_ptr <= dmem_rdata;
          r_state <= S_ACC;
        end
`endif
        S_ACC: if (dmem_resp) begin
          if (!w_store) r_rdata <= w_byte ? w_lane_rdata : dmem_rdata;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed checks against a transaction-level memory model.
module tb_mem_access_ctrl;
  import lc3b_types::*;
`ifdef LC3B_INDIRECT_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, dmem_resp = 1'b0;
  logic [2:0] req_op = 3'd0;
  logic [15:0] req_address = '0, req_wdata = '0, dmem_rdata = '0;
  logic [15:0] dmem_address, dmem_wdata, mem_rdata;
  logic dmem_read, dmem_write, mem_stall, mem_done;
  logic [1:0] dmem_wmask;
  logic [15:0] mem [32768];
  logic [15:0] m_rdata = '0;
  int n_chk = 0, n_pass = 0;
  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_address(req_address), .req_wdata(req_wdata), .dmem_address(dmem_address),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask
  task automatic run_txn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] w,
                         input int dly, input bit drop);
    bit ind, st, by, last, wr;
    int nacc, d;
    logic [15:0] ea, ptr, wd, rd;
    logic [1:0] wm;
    ind = IND_EN && (op == MOP_LDI || op == MOP_STI);
    st = op == MOP_STR || op == MOP_STB || op == MOP_STI;
    by = op == MOP_LDB || op == MOP_STB;
    nacc = ind ? 2 : 1;
    ptr = '0;
    rd = '0;
    @(negedge clk);
    dmem_resp = 1'b0;
    check("strb_idle", {14'd0, dmem_read, dmem_write}, 16'd0);
    req_valid = 1'b1; req_op = op; req_address = a; req_wdata = w;
    for (int k = 0; k < nacc; k++) begin
      last = k == nacc - 1;
      wr = last && st;
      ea = (ind && last) ? ptr : a;
      if (!(last && by)) ea[0] = 1'b0;
      wd = by ? {w[7:0], w[7:0]} : w;
      wm = by ? (ea[0] ? 2'b10 : 2'b01) : 2'b11;
      d = dly < 0 ? int'($urandom_range(0, 3)) : dly;
      for (int i = 0; i <= d; i++) begin
        @(negedge clk);
        dmem_resp = 1'b0;
        check("stall", {15'd0, mem_stall}, {15'd0, req_valid});
        check("rd", {15'd0, dmem_read}, {15'd0, !wr});
        check("wr", {15'd0, dmem_write}, {15'd0, wr});
        check("addr", dmem_address, ea);
        if (wr) begin
          check("wdata", dmem_wdata, wd);
          check("wmask", {14'd0, dmem_wmask}, {14'd0, wm});
        end
        if (k == 0 && i == 0) begin
          req_address = 16'($urandom); req_wdata = 16'($urandom);
          if (drop) req_valid = 1'b0;
        end
        if (i == d) begin
          dmem_resp = 1'b1;
          if (wr) begin
            if (wm[0]) mem[ea[15:1]][7:0] = wd[7:0];
            if (wm[1]) mem[ea[15:1]][15:8] = wd[15:8];
            dmem_rdata = 16'($urandom);
          end else begin
            rd = mem[ea[15:1]];
            dmem_rdata = rd;
            if (!last) ptr = rd;
          end
        end else dmem_rdata = 16'($urandom);
      end
    end
    if (!st) m_rdata = by ? {8'h00, ea[0] ? rd[15:8] : rd[7:0]} : rd;
    @(negedge clk);
    dmem_resp = 1'b0;
    check("done", {15'd0, mem_done}, 16'd1);
    check("stall_done", {15'd0, mem_stall}, 16'd0);
    check("strb_done", {14'd0, dmem_read, dmem_write}, 16'd0);
    check("rdata", mem_rdata, m_rdata);
    req_valid = 1'b0;
    dmem_resp = 1'($urandom_range(0, 1));
    dmem_rdata = 16'($urandom);
    @(negedge clk);
    dmem_resp = 1'b0;
    check("done_clr", {15'd0, mem_done}, 16'd0);
    check("strb_after", {14'd0, dmem_read, dmem_write}, 16'd0);
    check("rdata_hold", mem_rdata, m_rdata);
  endtask
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    repeat (2) @(negedge clk);
    check("rst_strb", {14'd0, dmem_read, dmem_write}, 16'd0);
    check("rst_done", {15'd0, mem_done}, 16'd0);
    check("rst_rdata", mem_rdata, 16'd0);
    check("rst_addr", dmem_address, 16'd0);
    check("rst_wdata", dmem_wdata, 16'd0);
    check("rst_stall", {15'd0, mem_stall}, 16'd0);
    reset = 1'b0;
    mem[15'h0801] = 16'hBEEF;
    run_txn(MOP_LDR, 16'h1003, 16'h0000, 0, 1'b0);
    check("ldr_beef", mem_rdata, 16'hBEEF);
    run_txn(MOP_STB, 16'h2001, 16'h00A5, 3, 1'b0);
    mem[15'h1000] = 16'h12F7;
    run_txn(MOP_LDB, 16'h2000, 16'h0000, 0, 1'b0);
    check("ldb_f7", mem_rdata, 16'h00F7);
    mem[15'h1800] = 16'h4000;
    mem[15'h2000] = 16'h5555;
    run_txn(MOP_LDI, 16'h3000, 16'h0000, 0, 1'b0);
    check("ldi_res", mem_rdata, IND_EN ? 16'h5555 : 16'h4000);
    @(negedge clk);
    req_valid = 1'b1; req_op = MOP_NONE; req_address = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("none_stall", {15'd0, mem_stall}, 16'd0);
      check("none_strb", {14'd0, dmem_read, dmem_write}, 16'd0);
      check("none_done", {15'd0, mem_done}, 16'd0);
    end
    req_valid = 1'b0;
    for (int n = 0; n < 150; n++)
      run_txn(3'($urandom_range(1, 6)), 16'($urandom_range(0, 63)), 16'($urandom), -1,
              $urandom_range(0, 3) == 0);
    run_txn(MOP_LDR, 16'h1002, 16'h0000, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_op = MOP_LDR; req_address = 16'h1002;
    @(negedge clk);
    check("acc_rd", {15'd0, dmem_read}, 16'd1);
    reset = 1'b1; dmem_resp = 1'b1; dmem_rdata = 16'hDEAD; req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_rd", {15'd0, dmem_read}, 16'd0);
    check("rst_mid_rdata", mem_rdata, 16'd0);
    check("rst_mid_done", {15'd0, mem_done}, 16'd0);
    check("rst_mid_addr", dmem_address, 16'd0);
    reset = 1'b0; dmem_resp = 1'b0; m_rdata = '0;
    @(negedge clk);
    check("post_rst_done", {15'd0, mem_done}, 16'd0);
    check("post_rst_rd", {15'd0, dmem_read}, 16'd0);
    run_txn(MOP_STR, 16'h0010, 16'hCAFE, -1, 1'b0);
    run_txn(MOP_LDR, 16'h0011, 16'h0000, -1, 1'b0);
    check("str_ldr", mem_rdata, 16'hCAFE);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters: none; all widths fixed by lc3b_types.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  MEM pipeline register holds a valid instruction.
REQ-005 req_op  input  lc3b_memop (3)  MOP_NONE, MOP_LDR, MOP_STR, MOP_LDB, MOP_STB, MOP_LDI, MOP_STI.
REQ-006 req_address  input  16  effective address from the MEM pipeline register.
REQ-007 req_wdata  input  16  store source data from the MEM pipeline register.
REQ-008 dmem_address  output  16  data-memory address.
REQ-009 dmem_read / dmem_write  output  1 each  memory strobes, held until dmem_resp.
REQ-010 dmem_wmask  output  2  byte enables; bit 0 is the low byte.
REQ-011 dmem_wdata  output  16  memory write data.
REQ-012 dmem_rdata  input  16  memory read data, valid with dmem_resp.
REQ-013 dmem_resp  input  1  one-cycle completion pulse from memory.
REQ-014 mem_stall  output  1  freezes all pipeline register loads.
REQ-015 mem_rdata  output  16  load result for the WB pipeline register.
REQ-016 mem_done  output  1  one-cycle pulse when the access completes.

Function
REQ-017 States SHALL be IDLE, IND, ACC and DONE.
REQ-018 IDLE: if req_valid and req_op != MOP_NONE, go to IND for LDI/STI, else go to ACC; otherwise stay in IDLE.
REQ-019 On leaving IDLE, the block SHALL register op, address and wdata, and SHALL ignore req_* inputs until it returns to IDLE.
REQ-020 IND: dmem_read=1 at {addr[15:1],1'b0}; on dmem_resp, latch ptr=dmem_rdata and go to ACC.
REQ-021 ACC: effective address = ptr for indirect ops, else the registered address; on dmem_resp, go to DONE.
REQ-022 Word ops (LDR/STR/LDI/STI): force address bit 0 to 0; wmask=2'b11; wdata=registered wdata.
REQ-023 LDB: mem_rdata={8'h00, addr[0] ? rdata[15:8] : rdata[7:0]}.
REQ-024 STB: wdata={wdata[7:0], wdata[7:0]}; wmask = addr[0] ? 2'b10 : 2'b01.
REQ-025 Loads: mem_rdata is latched on dmem_resp in ACC and held until the next load latches it.
REQ-026 Stores: mem_rdata is left unchanged.
REQ-027 DONE: mem_done=1 and mem_stall=0 for exactly one cycle, then go to IDLE.
REQ-028 mem_stall = req_valid & (req_op != MOP_NONE) & (state != DONE).
REQ-029 With zero-wait memory, minimum latency SHALL be 3 cycles (IDLE, ACC, DONE) for direct ops and 4 cycles for indirect ops.
REQ-030 dmem_read and dmem_write SHALL never be high together, and SHALL both be 0 in IDLE and DONE.
REQ-031 A dmem_resp that arrives in IDLE or DONE SHALL be ignored.
REQ-032 If req_valid drops mid-access, the access SHALL still complete, because memory transactions are not abortable.

Reset
REQ-033 While reset is high: state=IDLE; all outputs and internal registers (ptr, mem_rdata) = 0.
REQ-034 Reset asserted mid-access SHALL drop dmem_read/dmem_write on the next edge and discard the partial result.

Configuration
REQ-035 With LC3B_INDIRECT_EN defined, LDI/STI SHALL use the IND state.
REQ-036 With LC3B_INDIRECT_EN undefined, IND SHALL not exist, and LDI/STI SHALL execute as LDR/STR at req_address.

Structure
REQ-037 The lc3b_memop enum SHALL be added to the shared lc3b_types package.
REQ-038 The mem_state enum SHALL be local to the module.
REQ-039 Byte lane select/replicate logic SHALL be a sub-module, mem_byte_lane (combinational), shared with the IF-side load path.

Verification
REQ-040 LDR, addr 16'h1003, rdata 16'hBEEF with resp on the first ACC cycle -> dmem_address 16'h1002, mem_rdata 16'hBEEF, mem_done on cycle 2, mem_stall high on cycles 0-1.
REQ-041 STB, addr 16'h2001, wdata 16'h00A5 -> wdata 16'hA5A5, wmask 2'b10, dmem_write held through a 3-cycle resp delay.
REQ-042 LDB, addr 16'h2000, rdata 16'h12F7 -> mem_rdata 16'h00F7.
REQ-043 LDI (LC3B_INDIRECT_EN), addr 16'h3000, first rdata 16'h4000, second rdata 16'h5555 -> second dmem_address 16'h4000, mem_rdata 16'h5555, 4-cycle latency.
REQ-044 Reset pulse during ACC with resp pending -> next cycle state IDLE, dmem_read=0, mem_rdata=0, no mem_done.
REQ-045 MOP_NONE with req_valid=1 -> mem_stall=0, no memory strobes, state stays IDLE.
